// File: rtl/ccg_pipe_bench.sv
// Valid/ready pipeline computing duplicated group functions of the input vector,
// with a saturating delivery counter and an optional output MISR (CCG_MISR_EN).
module ccg_pipe_bench #(
  parameter int N_IN  = 20,
  parameter int N_OUT = 12,
  parameter int N_GRP = 2,
  parameter int LAT   = 2,
  parameter logic [N_OUT-1:0] POLY = N_OUT'(12'h829)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic [15:0]      vec_cnt
`ifdef CCG_MISR_EN
  ,
  input  logic             sig_clear,
  output logic [N_OUT-1:0] sig
`endif
);
  localparam int M = N_IN - 1;

  logic [N_GRP-1:0]            g;
  logic [N_OUT-1:0]            f;
  logic [LAT-1:0]              vld_pipe_q;
  logic [LAT-1:0][N_OUT-1:0]   dat_pipe_q;
  logic                        advance;
  logic                        out_fire;
  logic [15:0]                 vec_cnt_q, vec_cnt_d;
  logic                        unused_in;

  // Only a handful of input bits feed the group functions.
  assign unused_in = ^in_data;

  for (genvar k = 0; k < N_GRP; k++) begin : g_grp
    assign g[k] = in_data[M] & (in_data[(2*k+8) % M] ^ in_data[(2*k+6) % M]);
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign f[j] = g[j % N_GRP];
  end

  assign advance   = ~vld_pipe_q[LAT-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[LAT-1];
  assign out_data  = out_valid ? dat_pipe_q[LAT-1] : '0;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else if (advance) begin
      vld_pipe_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  // Data carries no reset; out_data is masked by the valid bit instead.
  always_ff @(posedge clk) begin
    if (advance) begin
      dat_pipe_q[0] <= f;
      for (int i = 1; i < LAT; i++) dat_pipe_q[i] <= dat_pipe_q[i-1];
    end
  end

  always_comb begin
    vec_cnt_d = vec_cnt_q;
    if (out_fire && vec_cnt_q != 16'hFFFF) vec_cnt_d = vec_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) vec_cnt_q <= '0;
    else     vec_cnt_q <= vec_cnt_d;
  end

  assign vec_cnt = vec_cnt_q;

`ifdef CCG_MISR_EN
  logic [N_OUT-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (rst || sig_clear) sig_q <= '0;
    else if (out_fire)
      sig_q <= {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? POLY : '0) ^ out_data;
  end

  assign sig = sig_q;
`endif
endmodule

// File: tb/tb_ccg_pipe_bench.sv
// Directed bench for ccg_pipe_bench at default parameters; MISR checks
// are compiled in when CCG_MISR_EN is defined.
module tb_ccg_pipe_bench;
  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [15:0] vec_cnt;
`ifdef CCG_MISR_EN
  logic        sig_clear;
  logic [11:0] sig;
`endif

  int checks = 0;
  int errors = 0;

  ccg_pipe_bench dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .vec_cnt(vec_cnt)
`ifdef CCG_MISR_EN
    , .sig_clear(sig_clear), .sig(sig)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [19:0] bp_vec [6] = '{20'h80100, 20'h80140, 20'h00140, 20'h80040, 20'h80400, 20'h80100};
  logic [11:0] bp_exp [6] = '{12'hFFF,   12'hAAA,   12'h000,   12'h555,   12'hAAA,   12'hFFF};

  initial begin
    int sent, got, n;
    logic        stall_prev;
    logic [11:0] stall_data;

    rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
`ifdef CCG_MISR_EN
    sig_clear = 0;
`endif
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
`ifdef CCG_MISR_EN
    chk("rst_sig", sig, 0);
`endif
    rst = 0;

    // single vector latency
    in_valid = 1; in_data = 20'h80100;
    tick();
    in_valid = 0;
    chk("lat_c1_valid", out_valid, 0);
    tick();
    chk("lat_c2_valid", out_valid, 1);
    chk("lat_c2_data", out_data, 12'hFFF);
    tick();
    chk("lat_cnt1", vec_cnt, 1);
    chk("lat_c3_valid", out_valid, 0);

    // back-to-back pair
    in_valid = 1; in_data = 20'h80140;
    tick();
    in_data = 20'h00140;
    tick();
    in_valid = 0;
    chk("pair_v0", out_valid, 1);
    chk("pair_d0", out_data, 12'hAAA);
    tick();
    chk("pair_v1", out_valid, 1);
    chk("pair_d1", out_data, 12'h000);
    tick();
    chk("pair_idle", out_valid, 0);
    chk("pair_cnt", vec_cnt, 3);

    // back-pressure: out_ready low for cycles 3..7
    sent = 0; got = 0; stall_prev = 0; stall_data = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (sent < 6);
      in_data   = (sent < 6) ? bp_vec[sent] : '0;
      #1;
      if (stall_prev) chk("bp_hold", {out_valid, out_data}, {1'b1, stall_data});
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        chk("bp_order", out_data, bp_exp[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_got", got, 6);
    tick();
    chk("bp_no_extra", out_valid, 0);
    chk("bp_cnt", vec_cnt, 9);

`ifdef CCG_MISR_EN
    sig_clear = 1;
    tick();
    sig_clear = 0;
    chk("misr_clr", sig, 0);
    in_valid = 1; in_data = 20'h80100;
    tick();
    in_data = 20'h80140;
    tick();
    in_valid = 0;
    tick();
    chk("misr_fff", sig, 12'hFFF);
    tick();
    chk("misr_d7d", sig, 12'hD7D);
    in_valid = 1; in_data = 20'h80100;
    tick();
    in_valid = 0;
    tick();
    chk("misr_pre_valid", out_valid, 1);
    sig_clear = 1;
    tick();
    sig_clear = 0;
    chk("misr_clr_prio", sig, 0);
`endif

    // reset with two vectors in flight
    in_valid = 1; in_data = 20'h80100;
    tick();
    in_data = 20'h80140;
    tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", vec_cnt, 0);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) n++;
      tick();
    end
    chk("mid_rst_stale", n, 0);
    chk("mid_rst_cnt2", vec_cnt, 0);

    // saturation
    in_valid = 1; in_data = 20'h80100; out_ready = 1; n = 0;
    for (int c = 0; c < 70000 && n < 65534; c++) begin
      if (out_valid && out_ready) n++;
      tick();
    end
    chk("sat_n", n, 65534);
    chk("sat_pre", vec_cnt, 16'd65534);
    tick();
    chk("sat_1", vec_cnt, 16'hFFFF);
    tick();
    chk("sat_2", vec_cnt, 16'hFFFF);
    tick();
    chk("sat_3", vec_cnt, 16'hFFFF);
    in_valid = 0;
    tick(); tick(); tick();
    chk("sat_hold", vec_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
